sobel_edge_combiner: RTL and testbench

- Downstream stage of the sequential Sobel X/Y pair.
- Consumes the per-pixel 10-bit |Gx| and |Gy| gradient magnitudes and forms an 8-bit saturated edge magnitude plus a thresholded binary edge flag.
- Tracks pixel position to tag start/end of line and frame.
- Two-stage pipeline with valid/ready handshake on both sides, so it can sit between the Sobel stages and a frame writer that may stall.

---
 rtl/sobel_pkg.sv | 12 +
 rtl/sobel_mag_sat.sv | 16 +
 rtl/sobel_edge_combiner.sv | 91 +++++++++
 tb/tb_sobel_edge_combiner.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, saturation limit and per-pixel position tag for the Sobel edge combiner.
package sobel_pkg;
    localparam int GRAD_W_DEF = 10;
    localparam int MAG_W_DEF = 8;
    localparam int MAG_MAX = (1 << MAG_W_DEF) - 1;
    typedef struct packed {
        logic sol;
        logic eol;
        logic sof;
        logic eof;
    } pix_tag_t;
endpackage

// File: rtl/sobel_mag_sat.sv
// sobel_mag_sat: gradient sum -> quarter-scale magnitude, saturated to MAG_W bits, compared against a threshold.
module sobel_mag_sat #(
    parameter int GRAD_W = 10,
    parameter int MAG_W = 8
) (
    input  logic [GRAD_W:0]  sum,
    input  logic [MAG_W-1:0] thr,
    output logic [MAG_W-1:0] mag,
    output logic             edge_hit
);
    localparam logic [GRAD_W:0] SAT = (GRAD_W+1)'((1 << MAG_W) - 1);
    logic [GRAD_W:0] sh;
    assign sh = sum >> 2;
    assign mag = (sh > SAT) ? '1 : sh[MAG_W-1:0];
    assign edge_hit = mag >= thr;
endmodule

// File: rtl/sobel_edge_combiner.sv
// sobel_edge_combiner: two-stage valid/ready pipeline turning |Gx|,|Gy| into a saturated magnitude,
// a thresholded edge flag and line/frame position tags.
module sobel_edge_combiner
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int GRAD_W = GRAD_W_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GRAD_W-1:0] sobel_x_in,
    input  logic [GRAD_W-1:0] sobel_y_in,
    input  logic [MAG_W-1:0]  threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MAG_W-1:0]  mag_out,
    output logic              edge_out,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_sof,
    output logic              out_eof,
    output logic              frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [MAG_W-1:0] thr_q, mag_d;
    logic [GRAD_W:0] s1_sum;
    logic s1_v, s2_v, s1_adv, s2_adv, accept, last_col, last_row, first_px, edge_d;
    pix_tag_t s1_tag, s2_tag;

    assign s2_adv = !s2_v || out_ready;
    assign s1_adv = !s1_v || s2_adv;
    assign in_ready = s1_adv;
    assign accept = in_valid && in_ready;
    assign last_col = col == CW'(IMG_WIDTH - 1);
    assign last_row = row == RW'(IMG_HEIGHT - 1);
    assign first_px = col == '0 && row == '0;
    assign out_valid = s2_v;
    assign out_sol = s2_tag.sol;
    assign out_eol = s2_tag.eol;
    assign out_sof = s2_tag.sof;
    assign out_eof = s2_tag.eof;

    // thr_q is already updated by the time pixel (0,0) moves into S2, so it sees its own frame's threshold
    sobel_mag_sat #(.GRAD_W(GRAD_W), .MAG_W(MAG_W)) u_sat (
        .sum(s1_sum),
        .thr(thr_q),
        .mag(mag_d),
        .edge_hit(edge_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            thr_q <= '0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_sum <= '0;
            s1_tag <= '0;
            s2_tag <= '0;
            mag_out <= '0;
            edge_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                s1_sum <= (GRAD_W+1)'(sobel_x_in) + (GRAD_W+1)'(sobel_y_in);
                s1_tag <= '{sol: col == '0, eol: last_col, sof: first_px, eof: last_col && last_row};
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
                if (first_px) thr_q <= threshold;
            end
            if (s1_adv) s1_v <= in_valid;
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    mag_out <= mag_d;
                    edge_out <= edge_d;
                    s2_tag <= s1_tag;
                end
            end
            frame_done <= s2_v && out_ready && s2_tag.eof;
        end
    end
endmodule

// File: tb/tb_sobel_edge_combiner.sv
// tb_sobel_edge_combiner: directed and randomized stimulus against a pixel-level scoreboard model.
module tb_sobel_edge_combiner;
    localparam int W = 4;
    localparam int H = 3;
    typedef struct {
        int mag;
        logic edg;
        logic [3:0] tags;
    } beat_t;

    logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [9:0] sobel_x_in, sobel_y_in;
    logic [7:0] threshold, mag_out;
    logic edge_out, out_sol, out_eol, out_sof, out_eof, frame_done;

    int total = 0, bad = 0;
    beat_t q[$];
    int p = 0, thr_m = 0;
    logic fd_exp = 0, stall_prev = 0, prev_edge = 0;
    logic [7:0] prev_mag = 0;
    logic [3:0] prev_tags = 0;

    sobel_edge_combiner #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sobel_x_in(sobel_x_in), .sobel_y_in(sobel_y_in), .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready), .mag_out(mag_out), .edge_out(edge_out),
        .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
        .frame_done(frame_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic iv, input int x, input int y, input logic ordy, input int thr);
        beat_t e;
        @(negedge clk);
        in_valid = iv;
        sobel_x_in = 10'(x);
        sobel_y_in = 10'(y);
        out_ready = ordy;
        threshold = 8'(thr);
        #1;
        chk("frame_done", frame_done, fd_exp);
        chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_mag", mag_out, prev_mag);
            chk("stall_edge", edge_out, prev_edge);
            chk("stall_tags", {out_sol, out_eol, out_sof, out_eof}, prev_tags);
        end
        fd_exp = 0;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_beat", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("mag", mag_out, e.mag);
                chk("edge", edge_out, e.edg);
                chk("tags", {out_sol, out_eol, out_sof, out_eof}, e.tags);
                fd_exp = e.tags[0];
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_mag = mag_out;
        prev_edge = edge_out;
        prev_tags = {out_sol, out_eol, out_sof, out_eof};
        if (iv && in_ready) begin
            if (p == 0) thr_m = thr;
            e.mag = (x + y) / 4 > 255 ? 255 : (x + y) / 4;
            e.edg = e.mag >= thr_m;
            e.tags = {p % W == 0, p % W == W - 1, p == 0, p == W * H - 1};
            q.push_back(e);
            p = (p + 1) % (W * H);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid = 0;
        out_ready = 0;
        #1;
        chk("pre_reset_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mag", mag_out, 0);
        chk("rst_tags", {out_sol, out_eol, out_sof, out_eof, frame_done}, 0);
        q.delete();
        p = 0;
        stall_prev = 0;
        fd_exp = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        sobel_x_in = 0;
        sobel_y_in = 0;
        threshold = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_mag", mag_out, 0);
        chk("reset_tags", {out_sol, out_eol, out_sof, out_eof, edge_out, frame_done}, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        step(1, 100, 60, 1, 50);
        step(1, 400, 300, 1, 50);
        step(1, 1023, 1023, 1, 50);
        step(1, 1020, 0, 1, 50);
        step(1, 512, 508, 1, 50);
        step(1, 511, 508, 1, 50);
        while (p != 0) step(1, $urandom_range(0, 1023), $urandom_range(0, 1023), 1, 50);
        for (int i = 0; i < W * H; i++)
            step(1, $urandom_range(0, 200), $urandom_range(0, 200), 1, i < 3 ? 100 : 10);
        for (int i = 0; i < W * H; i++)
            step(1, $urandom_range(0, 200), $urandom_range(0, 200), 1, 10);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 300),
                 i < 100 ? (i % 4 == 0 || i % 4 == 3) : $urandom_range(0, 1) == 1,
                 $urandom_range(0, 150));
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 1023), $urandom_range(0, 1023), 1, 40);
        repeat (3) step(1, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 40);
        mid_reset();
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1), $urandom_range(0, 400), $urandom_range(0, 400),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 150));
        repeat (8) step(0, 0, 0, 1, 0);
        chk("drain_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
